flag_cond_unit: RTL and testbench
=================================

// Module: flag_cond_unit
// PURPOSE
//  Holds the N/Z/V condition flags written by the EX-stage ALU, which includes the RED
//  reduction adder tree and the ADD/SUB/XOR/shift/PADDSB units. It sits directly
//  downstream of the ALU result mux.
//  It also evaluates the 3-bit branch condition for the instruction in ID.
//  When the instruction in EX writes flags in the same cycle, the EX flags are bypassed
//  to the branch logic, so no flag stall is needed.
// PARAMETERS
//  DW   16  datapath width of ex_result
//  OPW  4   opcode width
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst        in   1    synchronous reset, active-high
//  ex_valid   in   1    EX holds a real instruction (not a bubble)
//  ex_flush   in   1    kill the EX instruction this cycle (no flag write)
//  stall      in   1    pipeline stall; EX instruction is held, not retired
//  ex_opcode  in   OPW  opcode of the EX instruction
//  ex_result  in   DW   final ALU result (RED/ADD/etc.)
//  ex_ovfl    in   1    signed overflow from the ALU (ADD/SUB only meaningful)
//  id_is_br   in   1    ID holds B or BR
//  id_cc      in   3    condition code of the ID branch
//  flags      out  3    registered {N,Z,V}
//  br_taken   out  1    combinational; ID branch condition is true
// BEHAVIOUR
//  - Reset: when rst=1 at an edge, flags <= 3'b000; rst has priority over everything.
//    br_taken has no reset value of its own and is 0 whenever id_is_br=0.
//  - Write enable: we = ex_valid & ~ex_flush & ~stall.
//  - Flag classes (per opcode):
//    - ADD 0000, SUB 0001: write N, Z and V.
//    - XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110: write Z only.
//    - PADDSB 0111 and all other opcodes: no write.
//  - Flag values:
//    - Z = (ex_result == 0).
//    - N = ex_result[DW-1].
//    - V = ex_ovfl.
//    - Flags that are not written hold their previous value.
//  - Latency: the flag write is visible on flags one cycle after the EX edge.
//  - Stall: flags hold. The held EX instruction writes on the first non-stalled edge, once only.
//  - Flush:
//    - Suppresses the write in that cycle, including when stall is also asserted.
//    - Suppresses the bypass in that cycle.
//  - Bypass: eff = next-state flags computed as if we ignored stall, i.e. using
//    ex_valid & ~ex_flush & class(ex_opcode). Otherwise eff = flags.
//    The bypass applies during stall, because the EX instruction precedes the ID branch.
//  - Conditions, evaluated on eff:
//    000 NE: ~Z         001 EQ: Z            010 GT: ~Z & ~N
//    011 LT: N          100 GE: Z | ~N       101 LE: Z | N
//    110 OV: V          111 always 1
//  - br_taken = id_is_br & cond(id_cc, eff). It is purely combinational with no storage.
//  - Reset mid-stall discards the pending EX write.
//  - Width: only DW bits of ex_result are examined. For RED, the caller supplies the
//    sign-extended 16-bit sum.
// TESTING
//  1. Reset, then ADD with ex_result=0x0000 and ex_ovfl=0 → next cycle flags=3'b010.
//  2. With flags={1,0,1}: XOR with ex_result=0x0001 → flags={1,0,1}.
//     Then RED with ex_result=0x0000 → flags={1,1,1}.
//  3. With flags=000: SUB with ex_result=0xFFF0 in EX and ID BR with cc=011 in the same
//     cycle → br_taken=1 in that cycle; next cycle flags=3'b100.
//  4. ADD with ex_result=0 and ex_flush=1 → flags unchanged and no bypass.
//     A cc=001 branch in the same cycle → br_taken=0.
//  5. ADD with ex_result=0 under 3 cycles of stall → flags hold for 3 cycles and update
//     once on the 4th edge. Bypass EQ is taken throughout.
//  6. Assert rst during a stalled SUB that sets V → flags=000 the next cycle.
//     The SUB write is lost; cc=110 → br_taken=0.

Source files
------------

// File: rtl/flag_cond_if.sv
// Bundle between the EX/ID pipeline stages and the condition-flag unit.
interface flag_cond_if #(
  parameter int DW  = 16,
  parameter int OPW = 4
);
  logic           ex_valid;
  logic           ex_flush;
  logic           stall;
  logic [OPW-1:0] ex_opcode;
  logic [DW-1:0]  ex_result;
  logic           ex_ovfl;
  logic           id_is_br;
  logic [2:0]     id_cc;
  logic [2:0]     flags;
  logic           br_taken;

  modport master (
    output ex_valid, ex_flush, stall, ex_opcode, ex_result, ex_ovfl, id_is_br, id_cc,
    input  flags, br_taken
  );

  modport slave (
    input  ex_valid, ex_flush, stall, ex_opcode, ex_result, ex_ovfl, id_is_br, id_cc,
    output flags, br_taken
  );
endinterface

// File: rtl/flag_cond_unit.sv
// N/Z/V flag register written by the EX stage, plus branch-condition evaluation for ID
// with same-cycle bypass of the EX flag write.
module flag_cond_unit #(
  parameter int DW  = 16,
  parameter int OPW = 4
) (
  input  logic         clk,
  input  logic         rst,
  flag_cond_if.slave   bus
);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_RED = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_SLL = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_SRA = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_ROR = OPW'(4'b0110);

  logic [2:0] r_flags;
  logic       w_wr_nzv;
  logic       w_wr_z;
  logic       w_live;
  logic       w_we;
  logic       w_res_zero;
  logic [2:0] w_next;
  logic [2:0] w_eff;

  // Condition decode on {N,Z,V}.
  function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (cc)
      3'b000:  return ~z;
      3'b001:  return z;
      3'b010:  return ~z & ~n;
      3'b011:  return n;
      3'b100:  return z | ~n;
      3'b101:  return z | n;
      3'b110:  return v;
      3'b111:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Opcode flag classes; PADDSB and unlisted opcodes write nothing.
  always_comb begin
    w_wr_nzv = 1'b0;
    w_wr_z   = 1'b0;
    case (bus.ex_opcode)
      OP_ADD, OP_SUB:                         w_wr_nzv = 1'b1;
      OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR: w_wr_z   = 1'b1;
      default: begin
        w_wr_nzv = 1'b0;
        w_wr_z   = 1'b0;
      end
    endcase
  end

  assign w_res_zero = (bus.ex_result == {DW{1'b0}});
  assign w_live     = bus.ex_valid & ~bus.ex_flush;
  assign w_we       = w_live & ~bus.stall;

  // Candidate flags; unwritten fields keep the stored value.
  always_comb begin
    w_next[2] = w_wr_nzv ? bus.ex_result[DW-1] : r_flags[2];
    w_next[1] = (w_wr_nzv | w_wr_z) ? w_res_zero : r_flags[1];
    w_next[0] = w_wr_nzv ? bus.ex_ovfl : r_flags[0];
  end

  // The bypass ignores stall: the EX instruction is older than the ID branch.
  assign w_eff = w_live ? w_next : r_flags;

  // Flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 3'b000;
    end else if (w_we) begin
      r_flags <= w_next;
    end else begin
      r_flags <= r_flags;
    end
  end

  assign bus.flags    = r_flags;
  assign bus.br_taken = bus.id_is_br & cond_eval(bus.id_cc, w_eff);
endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed-vector bench for flag_cond_unit with a queue scoreboard and negedge monitor.
module tb_flag_cond_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    string      name;
    logic [2:0] f;
    logic       b;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  flag_cond_if #(.DW(16), .OPW(4)) bus ();

  flag_cond_unit #(.DW(16), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks = checks + 1;
      if (bus.flags !== e.f) begin
        errors = errors + 1;
        $display("FAIL %s flags: got %b expected %b", e.name, bus.flags, e.f);
      end
      checks = checks + 1;
      if (bus.br_taken !== e.b) begin
        errors = errors + 1;
        $display("FAIL %s br_taken: got %b expected %b", e.name, bus.br_taken, e.b);
      end
    end
  end

  task automatic step(input string name, input logic r, input logic v, input logic fl,
                      input logic st, input logic [3:0] op, input logic [15:0] res,
                      input logic ov, input logic br, input logic [2:0] cc,
                      input logic [2:0] exp_f, input logic exp_b);
    exp_t x;
    @(posedge clk);
    #1;
    rst          = r;
    bus.ex_valid = v;
    bus.ex_flush = fl;
    bus.stall    = st;
    bus.ex_opcode = op;
    bus.ex_result = res;
    bus.ex_ovfl  = ov;
    bus.id_is_br = br;
    bus.id_cc    = cc;
    x.name = name;
    x.f    = exp_f;
    x.b    = exp_b;
    sb_q.push_back(x);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_flush = 1'b0; bus.stall = 1'b0;
    bus.ex_opcode = 4'h0; bus.ex_result = 16'h0000; bus.ex_ovfl = 1'b0;
    bus.id_is_br = 1'b0; bus.id_cc = 3'b000;
    repeat (2) @(posedge clk);

    //    name          rst  v    fl   st   op     result    ov   br   cc      flags   br
    step("reset",       1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b0,3'b000, 3'b000, 1'b0);
    step("t1_add_byp",  1'b0,1'b1,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b000, 1'b1);
    step("t1_flags",    1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b000, 3'b010, 1'b0);
    step("t2_sub_ov",   1'b0,1'b1,1'b0,1'b0,4'h1,  16'h8000, 1'b1,1'b1,3'b110, 3'b010, 1'b1);
    step("t2_xor",      1'b0,1'b1,1'b0,1'b0,4'h2,  16'h0001, 1'b0,1'b1,3'b011, 3'b101, 1'b1);
    step("t2_red",      1'b0,1'b1,1'b0,1'b0,4'h3,  16'h0000, 1'b0,1'b1,3'b001, 3'b101, 1'b1);
    step("t2_after",    1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b010, 3'b111, 1'b0);
    step("t3_rst",      1'b1,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b0,3'b000, 3'b111, 1'b0);
    step("t3_sub_lt",   1'b0,1'b1,1'b0,1'b0,4'h1,  16'hFFF0, 1'b0,1'b1,3'b011, 3'b000, 1'b1);
    step("t3_after",    1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b100, 3'b100, 1'b0);
    step("t4_flush",    1'b0,1'b1,1'b1,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b100, 1'b0);
    step("t4_after",    1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b111, 3'b100, 1'b1);
    step("t5_stall1",   1'b0,1'b1,1'b0,1'b1,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b100, 1'b1);
    step("t5_stall2",   1'b0,1'b1,1'b0,1'b1,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b100, 1'b1);
    step("t5_stall3",   1'b0,1'b1,1'b0,1'b1,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b100, 1'b1);
    step("t5_release",  1'b0,1'b1,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b100, 1'b1);
    step("t5_written",  1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b000, 3'b010, 1'b0);
    step("t5_once",     1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b010, 1'b1);
    step("t6_stl_sub",  1'b0,1'b1,1'b0,1'b1,4'h1,  16'h0001, 1'b1,1'b1,3'b110, 3'b010, 1'b1);
    step("t6_rst",      1'b1,1'b1,1'b0,1'b1,4'h1,  16'h0001, 1'b1,1'b1,3'b110, 3'b010, 1'b1);
    step("t6_lost",     1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b110, 3'b000, 1'b0);
    step("paddsb",      1'b0,1'b1,1'b0,1'b0,4'h7,  16'h0000, 1'b1,1'b1,3'b001, 3'b000, 1'b0);
    step("paddsb_nowr", 1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b101, 3'b000, 1'b0);
    step("bubble",      1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b1,3'b001, 3'b000, 1'b0);
    step("bubble_nowr", 1'b0,1'b0,1'b0,1'b0,4'h0,  16'h0000, 1'b0,1'b0,3'b111, 3'b000, 1'b0);

    repeat (3) @(posedge clk);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
